lms_weight_update: RTL

- Consumes the eight step-scaled correction terms from the barrel shifter block and accumulates them into the eight LMS tap-weight registers: w(n+1) = w(n) + dw.
- Uses one shared saturating adder, time-multiplexed over the taps, with a valid/ready handshake on the delta bus.
- Weight outputs drive the FIR multiply stage.

---
 rtl/lms_weight_update.sv | 98 +++++++++
 1 files changed

// File: rtl/lms_weight_update.sv
// LMS tap-weight accumulator: eight weights updated one tap per cycle through a
// single shared (optionally saturating) adder, fed by a valid/ready delta bus.
module lms_weight_update #(
  parameter int unsigned WIDTH  = 10,
  parameter bit          SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dw1,
  input  logic [WIDTH-1:0] dw2,
  input  logic [WIDTH-1:0] dw3,
  input  logic [WIDTH-1:0] dw4,
  input  logic [WIDTH-1:0] dw5,
  input  logic [WIDTH-1:0] dw6,
  input  logic [WIDTH-1:0] dw7,
  input  logic [WIDTH-1:0] dw8,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic             clr,
  output logic [WIDTH-1:0] w1,
  output logic [WIDTH-1:0] w2,
  output logic [WIDTH-1:0] w3,
  output logic [WIDTH-1:0] w4,
  output logic [WIDTH-1:0] w5,
  output logic [WIDTH-1:0] w6,
  output logic [WIDTH-1:0] w7,
  output logic [WIDTH-1:0] w8,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state;
  logic [2:0]       idx;
  logic [WIDTH-1:0] w_q [8];
  logic [WIDTH-1:0] d_q [8];
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] add_res;

  // One extra bit of headroom; overflow shows as disagreement of the top two bits.
  always_comb begin
    sum_ext = {w_q[idx][WIDTH-1], w_q[idx]} + {d_q[idx][WIDTH-1], d_q[idx]};
    add_res = sum_ext[WIDTH-1:0];
    if (SAT_EN && (sum_ext[WIDTH] != sum_ext[WIDTH-1])) begin
      add_res = sum_ext[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= IDLE;
      idx   <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        w_q[i] <= '0;
        if (rst) d_q[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (upd_valid) begin
            d_q[0] <= dw1;
            d_q[1] <= dw2;
            d_q[2] <= dw3;
            d_q[3] <= dw4;
            d_q[4] <= dw5;
            d_q[5] <= dw6;
            d_q[6] <= dw7;
            d_q[7] <= dw8;
            idx    <= '0;
            state  <= ACC;
          end
        end
        ACC: begin
          w_q[idx] <= add_res;
          idx      <= idx + 3'd1;
          if (idx == 3'd7) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign upd_ready = (state == IDLE);
  assign busy      = (state == ACC);
  assign done      = (state == DONE);

  assign w1 = w_q[0];
  assign w2 = w_q[1];
  assign w3 = w_q[2];
  assign w4 = w_q[3];
  assign w5 = w_q[4];
  assign w6 = w_q[5];
  assign w7 = w_q[6];
  assign w8 = w_q[7];

endmodule
